fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/cpu_pkg.sv | 11 +
 rtl/fq_ram.sv | 34 +++
 rtl/fetch_queue.sv | 164 ++++++++++++++++
 tb/tb_fetch_queue.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants used by the fetch front end.
//   XLEN      : default datapath / PC width in bits
//   NOP_INSTR : value presented on the instruction bus when nothing is valid
//   PC_STEP   : byte increment between sequential instructions
package cpu_pkg;

  localparam int unsigned XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage : cpu_pkg

// File: rtl/fq_ram.sv
// Fetch queue storage: DEPTH x WIDTH register array, one synchronous write
// port and one asynchronous read port. Contents are not reset; the owner masks
// unused entries.
//   clk   : clock
//   we    : write enable
//   waddr : write index
//   wdata : write data
//   raddr : read index
//   rdata : read data (combinational from the array)
module fq_ram #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port.
  assign rdata = mem_q[raddr];

endmodule : fq_ram

// File: rtl/fetch_queue.sv
// Instruction fetch queue: fetches sequentially from a combinational
// instruction memory into a DEPTH-entry FIFO of {instr, pc+4}, stalls when
// full, flushes and refetches on a decode redirect.
// Optional macro FETCH_QUEUE_PERF_EN adds saturating performance counters.
//   clk, reset         : clock, synchronous active-high reset
//   imem_addr          : current fetch byte address
//   imem_rdata         : instruction at imem_addr (same cycle)
//   redirect_valid/pc  : flush and restart fetch at redirect_pc (word aligned)
//   deq_ready          : decode accepts the head entry
//   deq_valid          : head entry present
//   deq_instr          : head instruction (NOP when empty)
//   deq_pc_plus4       : head PC + 4 (zero when empty)
//   count              : occupied entries
//   perf_fetched/perf_redirects/perf_full_cycles : counters (macro only)
module fetch_queue #(
  parameter int unsigned XLEN     = cpu_pkg::XLEN,
  parameter int unsigned DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [XLEN-1:0]        imem_addr,
  input  logic [XLEN-1:0]        imem_rdata,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  input  logic                   deq_ready,
  output logic                   deq_valid,
  output logic [XLEN-1:0]        deq_instr,
  output logic [XLEN-1:0]        deq_pc_plus4,
  output logic [$clog2(DEPTH):0] count
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_redirects,
  output logic [31:0]            perf_full_cycles
`endif
);

  import cpu_pkg::*;

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic              deq_fire_c;
  logic              enq_fire_c;
  logic              ram_we_c;
  logic [XLEN-1:0]   pc_next_c;
  logic [2*XLEN-1:0] ram_rdata_c;

  assign deq_valid  = (count_q != '0);
  assign deq_fire_c = deq_valid & deq_ready & ~redirect_valid;
  // A dequeue in the same cycle frees the slot, so a full queue keeps fetching.
  assign enq_fire_c = ~redirect_valid & ((count_q < CNT_W'(DEPTH)) | deq_fire_c);
  assign ram_we_c   = enq_fire_c & ~reset;
  assign pc_next_c  = fetch_pc_q + XLEN'(PC_STEP);

  // Entry layout: {instr, pc_plus4}.
  fq_ram #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_c),
    .waddr (tail_q),
    .wdata ({imem_rdata, pc_next_c}),
    .raddr (head_q),
    .rdata (ram_rdata_c)
  );

  // Next-state for pointers, occupancy and fetch PC; redirect has priority.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~XLEN'(3);
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (enq_fire_c) begin
        tail_d     = tail_q + PTR_W'(1);
        fetch_pc_d = pc_next_c;
      end
      if (deq_fire_c) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({enq_fire_c, deq_fire_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  assign imem_addr    = fetch_pc_q;
  assign count        = count_q;
  // Storage is never cleared, so stale entries are hidden when empty.
  assign deq_instr    = deq_valid ? ram_rdata_c[2*XLEN-1:XLEN] : XLEN'(NOP_INSTR);
  assign deq_pc_plus4 = deq_valid ? ram_rdata_c[XLEN-1:0]      : '0;

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_fetched_q,     perf_fetched_d;
  logic [31:0] perf_redirects_q,   perf_redirects_d;
  logic [31:0] perf_full_cycles_q, perf_full_cycles_d;
  logic        full_stall_c;

  assign full_stall_c = (count_q == CNT_W'(DEPTH)) & ~deq_fire_c;

  // Saturating event counters.
  always_comb begin
    perf_fetched_d     = perf_fetched_q;
    perf_redirects_d   = perf_redirects_q;
    perf_full_cycles_d = perf_full_cycles_q;
    if (enq_fire_c && perf_fetched_q != '1) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end
    if (redirect_valid && perf_redirects_q != '1) begin
      perf_redirects_d = perf_redirects_q + 32'd1;
    end
    if (full_stall_c && perf_full_cycles_q != '1) begin
      perf_full_cycles_d = perf_full_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q     <= '0;
      perf_redirects_q   <= '0;
      perf_full_cycles_q <= '0;
    end else begin
      perf_fetched_q     <= perf_fetched_d;
      perf_redirects_q   <= perf_redirects_d;
      perf_full_cycles_q <= perf_full_cycles_d;
    end
  end

  assign perf_fetched     = perf_fetched_q;
  assign perf_redirects   = perf_redirects_q;
  assign perf_full_cycles = perf_full_cycles_q;
`endif

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue (XLEN=32, DEPTH=4, RESET_PC=0).
// A queue-based reference model predicts the entries decode should receive;
// a negedge monitor pops and compares them on every DUT handshake.
module tb_fetch_queue;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        deq_ready;
  logic        deq_valid;
  logic [31:0] deq_instr;
  logic [31:0] deq_pc_plus4;
  logic [2:0]  count;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_redirects;
  logic [31:0] perf_full_cycles;
`endif

  fetch_queue #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .deq_ready      (deq_ready),
    .deq_valid      (deq_valid),
    .deq_instr      (deq_instr),
    .deq_pc_plus4   (deq_pc_plus4),
    .count          (count)
`ifdef FETCH_QUEUE_PERF_EN
    ,
    .perf_fetched     (perf_fetched),
    .perf_redirects   (perf_redirects),
    .perf_full_cycles (perf_full_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-indexed instruction memory contents.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E37_79B1) ^ 32'h1357_0F0F;
  endfunction

  always_comb imem_rdata = mem_word(imem_addr);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  ent_t        model_q[$];
  ent_t        sb_q[$];
  ent_t        mon_e;
  logic [31:0] model_pc;
  bit          model_known = 1'b0;
  int unsigned m_fetched, m_redirects, m_full;

  bit          cur_check = 1'b0;
  logic [31:0] cur_addr;
  int unsigned cur_count;
  bit          cur_valid;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus, advance the reference model, and return just
  // after the edge.
  task automatic step(input bit rst, input bit redir, input logic [31:0] rpc, input bit rdy);
    bit deq;
    bit enq;
    reset          = rst;
    redirect_valid = redir;
    redirect_pc    = rpc;
    deq_ready      = rdy;
    cur_check = model_known;
    cur_addr  = model_pc;
    cur_count = model_q.size();
    cur_valid = (model_q.size() != 0);
    if (rst) begin
      model_q.delete();
      model_pc    = RESET_PC;
      model_known = 1'b1;
      m_fetched   = 0;
      m_redirects = 0;
      m_full      = 0;
    end else if (redir) begin
      if (model_q.size() == DEPTH) m_full++;
      model_q.delete();
      model_pc = rpc & ~32'h3;
      m_redirects++;
    end else begin
      deq = (model_q.size() != 0) && rdy;
      enq = (model_q.size() < DEPTH) || deq;
      if (model_q.size() == DEPTH && !deq) m_full++;
      if (deq) sb_q.push_back(model_q.pop_front());
      if (enq) begin
        model_q.push_back('{instr: mem_word(model_pc), pc4: model_pc + 32'd4});
        model_pc = model_pc + 32'd4;
        m_fetched++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: per-cycle state checks plus scoreboard pop on each handshake.
  always @(negedge clk) begin
    if (cur_check) begin
      chk("imem_addr", imem_addr, cur_addr);
      chk("count", 32'(count), cur_count);
      chk("deq_valid", 32'(deq_valid), 32'(cur_valid));
      if (!deq_valid) begin
        chk("nop_when_empty", deq_instr, 32'h0);
      end else if (deq_ready && !redirect_valid && !reset) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected_deq: got instr %h with no expected entry", deq_instr);
        end else begin
          mon_e = sb_q.pop_front();
          chk("deq_instr", deq_instr, mon_e.instr);
          chk("deq_pc_plus4", deq_pc_plus4, mon_e.pc4);
        end
      end
    end
  end

  initial begin
    bit          r_rst, r_redir, r_rdy;
    logic [31:0] r_pc;
    int unsigned r;

    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; deq_ready = 1'b0;

    // Reset state.
    step(1, 0, 0, 0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(deq_valid), 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_instr", deq_instr, 32'h0);
    chk("rst_pc4", deq_pc_plus4, 32'h0);

    // Streaming with decode always ready.
    step(0, 0, 0, 1);
    chk("stream_valid", 32'(deq_valid), 32'd1);
    chk("stream_w0", deq_instr, mem_word(32'h0));
    chk("stream_pc4_0", deq_pc_plus4, 32'd4);
    step(0, 0, 0, 1);
    chk("stream_w1", deq_instr, mem_word(32'h4));
    chk("stream_pc4_1", deq_pc_plus4, 32'd8);
    repeat (4) step(0, 0, 0, 1);

    // Decode stalled: fill and hold, then full with simultaneous enq/deq.
    step(1, 0, 0, 0);
    repeat (10) step(0, 0, 0, 0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_addr", imem_addr, 32'd16);
    step(0, 0, 0, 1);
    chk("full_flow_count", 32'(count), 32'd4);
    chk("full_flow_addr", imem_addr, 32'd20);
    step(0, 0, 0, 1);
    chk("full_flow_addr2", imem_addr, 32'd24);
    repeat (6) step(0, 0, 0, 1);

    // Redirect with 3 entries queued; misaligned target.
    step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    chk("pre_redir_count", 32'(count), 32'd3);
    step(0, 1, 32'h0000_0103, 0);
    chk("redir_count", 32'(count), 32'd0);
    chk("redir_addr", imem_addr, 32'h0000_0100);
    step(0, 0, 0, 0);
    chk("redir_target", deq_instr, mem_word(32'h0000_0100));

    // Back-to-back redirects: last one wins.
    step(0, 1, 32'h0000_0200, 1);
    step(0, 1, 32'h0000_0304, 1);
    chk("b2b_addr", imem_addr, 32'h0000_0304);
    step(0, 0, 0, 1);
    chk("b2b_target", deq_instr, mem_word(32'h0000_0304));

    // Reset beats a simultaneous redirect.
    step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    step(1, 1, 32'h0000_0500, 1);
    chk("rst_redir_count", 32'(count), 32'd0);
    chk("rst_redir_addr", imem_addr, RESET_PC);
    chk("rst_redir_valid", 32'(deq_valid), 32'd0);

    // PC wraps modulo 2^32.
    step(0, 1, 32'hFFFF_FFF8, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    repeat (3) step(0, 0, 0, 1);

`ifdef FETCH_QUEUE_PERF_EN
    // 1 redirect, 5 enqueues, 2 full-stall cycles.
    step(1, 0, 0, 0);
    step(0, 1, 32'h0, 0);
    repeat (6) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("perf_fetched_dir", perf_fetched, 32'd5);
    chk("perf_redirects_dir", perf_redirects, 32'd1);
    chk("perf_full_dir", perf_full_cycles, 32'd2);
`endif

    // Randomized traffic.
    repeat (3000) begin
      r       = $urandom;
      r_rst   = (r % 97) == 0;
      r_redir = ((r >> 8) % 8) == 0;
      r_rdy   = ((r >> 16) % 4) != 0;
      if (((r >> 12) % 4) == 0) r_pc = 32'hFFFF_FFF0 | ((r >> 20) & 32'hF);
      else                      r_pc = $urandom;
      step(r_rst, r_redir, r_pc, r_rdy);
    end
    step(0, 0, 0, 0);

    chk("sb_leftover", sb_q.size(), 32'd0);
`ifdef FETCH_QUEUE_PERF_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_redirects", perf_redirects, m_redirects);
    chk("perf_full_cycles", perf_full_cycles, m_full);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_fetch_queue
